// File: rtl/freq_div.sv
`default_nettype none
// ============================================================================
// Module   : freq_div
// Brief    : Measures the period of slow clock f in clk cycles and emits a
//            near-50% duty f/M clock, phase-relocked on every M-th f edge.
// Revision : 1.0 - initial release
// ============================================================================
module freq_div #(
    parameter int PW = 16,
    parameter int MW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          f,
    input  logic          adjust,
    input  logic [MW-1:0] m,
    output logic          valid,
    output logic          div_out,
    output logic [PW-1:0] period
);

    localparam int FW = MW + PW;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ARM  = 2'd1;
    localparam logic [1:0] S_MEAS = 2'd2;
    localparam logic [1:0] S_RUN  = 2'd3;

    localparam logic [PW-1:0] c_cnt_max = '1;

    logic          r_f_meta;
    logic          r_f_sync;
    logic          r_f_prev;
    logic [1:0]    r_state;
    logic [MW-1:0] r_m;
    logic [PW-1:0] r_cnt;
    logic [PW-1:0] r_period;
    logic [MW-1:0] r_ecnt;
    logic [FW-1:0] r_tmr;
    logic          r_valid;
    logic          r_div;

    logic          w_f_rise;
    logic [FW-1:0] w_full;
    logic [FW-1:0] w_full_sh;
    logic [FW-1:0] w_half;
    logic [FW-1:0] w_tmr_p1;
    logic [FW-1:0] w_tmr_inc;
    logic [MW:0]   w_ecnt_p1;

    logic [1:0]    w_state_nxt;
    logic [MW-1:0] w_m_nxt;
    logic [PW-1:0] w_cnt_nxt;
    logic [PW-1:0] w_period_nxt;
    logic [MW-1:0] w_ecnt_nxt;
    logic [FW-1:0] w_tmr_nxt;
    logic          w_valid_nxt;
    logic          w_div_nxt;

    assign w_f_rise  = r_f_sync & ~r_f_prev;
    assign w_full    = FW'(r_m) * FW'(r_period);
    assign w_full_sh = w_full >> 1;
    assign w_half    = (w_full_sh == '0) ? FW'(1) : w_full_sh;
    // Saturate at full-1 so a late f edge cannot wrap the phase timer.
    assign w_tmr_p1  = r_tmr + FW'(1);
    assign w_tmr_inc = (w_tmr_p1 < w_full) ? w_tmr_p1 : r_tmr;
    assign w_ecnt_p1 = {1'b0, r_ecnt} + (MW+1)'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_f_meta <= 1'b0;
            r_f_sync <= 1'b0;
            r_f_prev <= 1'b0;
        end else begin
            r_f_meta <= f;
            r_f_sync <= r_f_meta;
            r_f_prev <= r_f_sync;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_m_nxt      = r_m;
        w_cnt_nxt    = r_cnt;
        w_period_nxt = r_period;
        w_ecnt_nxt   = r_ecnt;
        w_tmr_nxt    = r_tmr;

        if (adjust) begin
            w_m_nxt     = (m == '0) ? MW'(1) : m;
            w_state_nxt = S_ARM;
            w_cnt_nxt   = '0;
            w_ecnt_nxt  = '0;
            w_tmr_nxt   = '0;
        end else begin
            case (r_state)
                S_IDLE: ;
                S_ARM: begin
                    if (w_f_rise) begin
                        w_cnt_nxt   = PW'(1);
                        w_state_nxt = S_MEAS;
                    end
                end
                S_MEAS: begin
                    if (w_f_rise) begin
                        w_period_nxt = r_cnt;
                        w_cnt_nxt    = '0;
                        w_ecnt_nxt   = '0;
                        w_tmr_nxt    = '0;
                        w_state_nxt  = S_RUN;
                    end else if (r_cnt == c_cnt_max) begin
                        w_period_nxt = '0;
                        w_cnt_nxt    = '0;
                        w_state_nxt  = S_IDLE;
                    end else begin
                        w_cnt_nxt = r_cnt + PW'(1);
                    end
                end
                S_RUN: begin
                    // r_cnt is reused here as the gap since the last f edge.
                    if (w_f_rise) begin
                        w_cnt_nxt = '0;
                        if (w_ecnt_p1 == {1'b0, r_m}) begin
                            w_ecnt_nxt = '0;
                            w_tmr_nxt  = '0;
                        end else begin
                            w_ecnt_nxt = w_ecnt_p1[MW-1:0];
                            w_tmr_nxt  = w_tmr_inc;
                        end
                    end else if (r_cnt == c_cnt_max) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_cnt_nxt = r_cnt + PW'(1);
                        w_tmr_nxt = w_tmr_inc;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end

        w_valid_nxt = (w_state_nxt == S_RUN);
        w_div_nxt   = w_valid_nxt && (w_tmr_nxt < w_half);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_m      <= MW'(1);
            r_cnt    <= '0;
            r_period <= '0;
            r_ecnt   <= '0;
            r_tmr    <= '0;
            r_valid  <= 1'b0;
            r_div    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_m      <= w_m_nxt;
            r_cnt    <= w_cnt_nxt;
            r_period <= w_period_nxt;
            r_ecnt   <= w_ecnt_nxt;
            r_tmr    <= w_tmr_nxt;
            r_valid  <= w_valid_nxt;
            r_div    <= w_div_nxt;
        end
    end

    assign valid   = r_valid;
    assign div_out = r_div;
    assign period  = r_period;

endmodule
`default_nettype wire

// File: doc/freq_div.md
Name: freq_div

Overview:
- Programmable frequency divider. Counterpart to the frequency multiplier in the same clocking subsystem.
- Measures the period of a slow external clock `f` in reference-clock (`clk`) cycles.
- Generates `div_out` at f/M with near-50% duty, even for odd M. Phase is re-locked to every M-th rising edge of `f`.
- Uses the same adjust/valid handshake as the multiplier, so the CPU-clock controller can drive either block.

Parameters:
- `PW`, 16: width of the period counter and of the `period` output.
- `MW`, 8: width of the divide ratio `m`.

Ports:
- `clk`  input  1  reference clock. All logic is in this domain.
- `rst`  input  1  asynchronous, active-high reset.
- `f`  input  1  asynchronous input clock to be divided.
- `adjust`  input  1  one-cycle request: latch `m` and (re)start measurement.
- `m`  input  MW  divide ratio, sampled only when `adjust`=1.
- `valid`  output  1  high while `div_out` is a locked f/M waveform.
- `div_out`  output  1  divided clock output.
- `period`  output  PW  last measured `f` period, in `clk` cycles.

Behaviour:
- **Reset.** One clock; reset is asynchronous and active-high (`rst`). While `rst`=1, and on the cycle after release:
  - state=IDLE;
  - `valid`=0, `div_out`=0, `period`=0;
  - all counters cleared.
  - Reset applies in any state, including mid-measurement.
- **Input conditioning.** `f` passes through a 2-flop synchronizer, then a rising-edge detector.
  - `f_rise` is a one-cycle pulse, 2–3 `clk` cycles after the `f` edge.
  - All `f`-related events below refer to `f_rise`.
- **Ratio latch.** On `adjust`=1, `m_r` <= (`m`==0 ? 1 : `m`).
- **State IDLE.** `valid`=0, `div_out`=0. On `adjust` -> ARM.
- **State ARM.** Wait for `f_rise`. On `f_rise`: `cnt`<=1, -> MEAS.
- **State MEAS.** `cnt` increments every cycle.
  - On `f_rise`: `period`<=`cnt`, `tmr`<=0, `ecnt`<=0, `div_out`<=1, -> RUN.
  - `period` equals the `f_rise`-to-`f_rise` distance in `clk` cycles.
  - If `cnt` reaches 2^PW-1 with no `f_rise`: timeout -> IDLE, `period`<=0.
- **State RUN.** `valid`=1.
  - `full` = `m_r`*`period`, MW+PW bits wide and unsigned.
  - `half` = max(1, `full`>>1).
  - `tmr` increments each cycle and saturates at `full`-1.
  - `div_out` is registered; its next value is (`tmr_next` < `half`).
  - On `f_rise`: `ecnt` increments. When `ecnt`+1 == `m_r`: `ecnt`<=0, `tmr`<=0, `div_out`<=1 (phase re-lock).
  - Result: high for `half` cycles, low for `full`-`half` cycles (odd `full` gives one extra low cycle).
  - If the idle gap since the last `f_rise` reaches 2^PW-1 cycles: -> IDLE. `valid` and `div_out` drop the next cycle; `period` holds its last value.
- **`adjust` in ARM, MEAS or RUN.** Relatch `m_r`, -> ARM; `valid`<=0, `div_out`<=0 the next cycle. `adjust` has priority over a simultaneous `f_rise`.
- **Measurement scope.** The period is measured once per adjust; RUN does not re-measure.
- **Registering.** `valid`, `div_out` and `period` are registered; no combinational path from inputs.
- **`f` faster than `clk`/4.** Unsupported. Edges may be missed; no error flag.

Test Plan:
1. **Basic odd-ratio lock.** `f` period 50 `clk`, `m`=3, pulse `adjust`.
   - `period`=50.
   - `valid` rises after the second `f_rise` following `adjust`.
   - `div_out` is 75 high / 75 low, repeating; re-lock every 3rd `f_rise` with no phase drift.
2. **Even ratio, short period.** `f` period 10 `clk`, `m`=4 -> `period`=10, `div_out` 20 high / 20 low. Then `m`=0 with `adjust` -> treated as 1, `div_out` 5 high / 5 low.
3. **Odd full count.** `f` period 7, `m`=1 -> `full`=7, `div_out` 3 high / 4 low.
4. **Re-adjust mid-run.** In RUN (`f` period 50, `m`=2), pulse `adjust` with `m`=5.
   - `valid`=0 and `div_out`=0 the next cycle.
   - Re-measure gives `period`=50, then 125 high / 125 low.
   - Also assert `adjust` in the same cycle as `f_rise` -> state ARM.
5. **Timeout.** Stop toggling `f` during MEAS -> IDLE after 65535 cycles, `period`=0. Stop `f` during RUN -> IDLE, `valid`=0, `period` retained.
6. **Reset mid-operation.** Assert `rst` asynchronously mid-MEAS and again mid-RUN, between `clk` edges.
   - Outputs go to 0 immediately.
   - After release the block stays in IDLE until `adjust`.
